// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet layer scheduler slice.
//   - default widths for the shared bias_weights / result BRAM ports
//   - layer index constants (engine run order)
//   - scheduler state encoding (one-hot)
package lenet_pkg;

    localparam int LENET_NUM_LAYERS = 6;
    localparam int LENET_DATA_SIZE  = 8;
    localparam int LENET_WADDR_W    = 19;
    localparam int LENET_RADDR_W    = 15;
    localparam int LENET_IDX_W      = 3;

    localparam int L_CONV1 = 0;
    localparam int L_POOL1 = 1;
    localparam int L_CONV2 = 2;
    localparam int L_POOL2 = 3;
    localparam int L_FC1   = 4;
    localparam int L_FC2   = 5;

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_SEEK   = 6'b000010,
        S_LAUNCH = 6'b000100,
        S_RUN    = 6'b001000,
        S_DRAIN  = 6'b010000,
        S_DONE   = 6'b100000
    } sched_state_e;

endpackage

// File: rtl/lenet_layer_sched_if.sv
// Engine-side handshake and shared BRAM port A bundle of the layer scheduler.
//   master : the scheduler (drives layer_en and the BRAM port, reads engine requests)
//   slave  : the engines / BRAM side
//   layer_en / layer_finish      one bit per engine
//   eng_*                        per-engine BRAM requests, engine i at [i*W +: W]
//   bias_weights_bram_* / result_bram_*   muxed port A of the shared BRAMs
interface lenet_layer_sched_if
    import lenet_pkg::*;
#(
    parameter int NUM_LAYERS = LENET_NUM_LAYERS,
    parameter int DATA_SIZE  = LENET_DATA_SIZE,
    parameter int WADDR_W    = LENET_WADDR_W,
    parameter int RADDR_W    = LENET_RADDR_W
);

    logic [NUM_LAYERS-1:0]           layer_en;
    logic [NUM_LAYERS-1:0]           layer_finish;
    logic [NUM_LAYERS-1:0]           eng_bw_ena;
    logic [NUM_LAYERS*WADDR_W-1:0]   eng_bw_addra;
    logic [NUM_LAYERS-1:0]           eng_rs_ena;
    logic [NUM_LAYERS-1:0]           eng_rs_wea;
    logic [NUM_LAYERS*RADDR_W-1:0]   eng_rs_addra;
    logic [NUM_LAYERS*DATA_SIZE-1:0] eng_rs_dina;

    logic                            bias_weights_bram_ena;
    logic [WADDR_W-1:0]              bias_weights_bram_addra;
    logic                            result_bram_ena;
    logic                            result_bram_wea;
    logic [RADDR_W-1:0]              result_bram_addra;
    logic [DATA_SIZE-1:0]            result_bram_dina;

    modport master (
        output layer_en,
        output bias_weights_bram_ena, bias_weights_bram_addra,
        output result_bram_ena, result_bram_wea, result_bram_addra, result_bram_dina,
        input  layer_finish,
        input  eng_bw_ena, eng_bw_addra,
        input  eng_rs_ena, eng_rs_wea, eng_rs_addra, eng_rs_dina
    );

    modport slave (
        input  layer_en,
        input  bias_weights_bram_ena, bias_weights_bram_addra,
        input  result_bram_ena, result_bram_wea, result_bram_addra, result_bram_dina,
        output layer_finish,
        output eng_bw_ena, eng_bw_addra,
        output eng_rs_ena, eng_rs_wea, eng_rs_addra, eng_rs_dina
    );

endinterface

// File: rtl/lenet_bram_port_mux.sv
// N:1 combinational mux of one BRAM port A.
// The per-engine request is {ena, payload}; payload carries wea/addr/dina
// packed by the caller (just addr for a read-only port).
//   force_off  1 = port idle: ena=0, payload=0
//   sel        engine index to pass through
//   ena_in     per-engine ena, pay_in per-engine payload at [i*PW +: PW]
//   ena / pay  to the BRAM
module lenet_bram_port_mux #(
    parameter int N     = 6,
    parameter int PW    = 19,
    parameter int SEL_W = 3
) (
    input  logic             force_off,
    input  logic [SEL_W-1:0] sel,
    input  logic [N-1:0]     ena_in,
    input  logic [N*PW-1:0]  pay_in,
    output logic             ena,
    output logic [PW-1:0]    pay
);

    always_comb begin
        ena = 1'b0;
        pay = '0;
        if (!force_off && (int'(sel) < N)) begin
            ena = ena_in[sel];
            pay = pay_in[int'(sel)*PW +: PW];
        end
    end

endmodule

// File: rtl/lenet_layer_sched.sv
// Top-level sequencer for the LeNet engines (conv_1 .. fc_2).
// Runs the layers selected by layer_mask one at a time in index order using
// each engine's en/finish handshake, and hands the shared bias_weights and
// result BRAM port A to the active engine only.
//   start/abort/layer_mask   pass control (mask sampled when start is accepted)
//   busy/done/error          pass status; error is sticky until the next start
//   layer_idx                current or last layer
//   bus (master)             engine en/finish, engine BRAM requests, BRAM port A
//
// state    | meaning
// S_IDLE   | waiting for start
// S_SEEK   | pick lowest masked layer >= search pointer
// S_LAUNCH | raise that engine's en, clear watchdog
// S_RUN    | engine running; wait for finish or watchdog
// S_DRAIN  | en low for one cycle so the engine parks
// S_DONE   | one-cycle done pulse
module lenet_layer_sched
    import lenet_pkg::*;
#(
    parameter int NUM_LAYERS = LENET_NUM_LAYERS,
    parameter int DATA_SIZE  = LENET_DATA_SIZE,
    parameter int WADDR_W    = LENET_WADDR_W,
    parameter int RADDR_W    = LENET_RADDR_W,
    parameter int TIMEOUT_W  = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_LAYERS-1:0]  layer_mask,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [LENET_IDX_W-1:0] layer_idx,
    lenet_layer_sched_if.master    bus
);

    localparam int RS_PW = 1 + RADDR_W + DATA_SIZE;
    // Last watchdog value before saturation: en stays high 2**TIMEOUT_W-1 cycles.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [LENET_IDX_W-1:0] IDX_LAST = LENET_IDX_W'(NUM_LAYERS-1);

    sched_state_e             state_q, state_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic [LENET_IDX_W-1:0]   idx_q, idx_d;
    logic [LENET_IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_LAYERS-1:0]    en_q, en_d;
    logic [NUM_LAYERS-1:0]    mask_q, mask_d;
    logic [TIMEOUT_W-1:0]     wd_q, wd_d;

    logic                     found;
    logic [LENET_IDX_W-1:0]   found_idx;

    // Descending scan so the lowest qualifying index is the one kept.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (mask_q[i] && (i >= int'(ptr_q))) begin
                found     = 1'b1;
                found_idx = LENET_IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        en_d    = en_q;
        mask_d  = mask_q;
        wd_d    = wd_q;
        if ((state_q != S_IDLE) && abort) begin
            // abort wins over a finish arriving on the same edge
            state_d = S_IDLE;
            en_d    = '0;
            busy_d  = 1'b0;
            error_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        mask_d  = layer_mask;
                        error_d = 1'b0;
                        busy_d  = 1'b1;
                        idx_d   = LENET_IDX_W'(L_CONV1);
                        ptr_d   = LENET_IDX_W'(L_CONV1);
                        state_d = S_SEEK;
                    end
                end
                S_SEEK: begin
                    if (found) begin
                        idx_d   = found_idx;
                        state_d = S_LAUNCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_LAUNCH: begin
                    en_d        = '0;
                    en_d[idx_q] = 1'b1;
                    wd_d        = '0;
                    state_d     = S_RUN;
                end
                S_RUN: begin
                    // wd_q==0 is the first en-high cycle; a finish seen there is stale
                    if (bus.layer_finish[idx_q] && (wd_q != '0)) begin
                        en_d    = '0;
                        state_d = S_DRAIN;
                    end else if (wd_q == WD_LAST) begin
                        en_d    = '0;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (idx_q == IDX_LAST) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = idx_q + 1'b1;
                        state_d = S_SEEK;
                    end
                end
                S_DONE: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    en_d    = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
            en_q    <= '0;
            mask_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            en_q    <= en_d;
            mask_q  <= mask_d;
            wd_q    <= wd_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign layer_idx    = idx_q;
    assign bus.layer_en = en_q;

    // The engine keeps the port through DRAIN so a trailing write lands.
    logic port_off;
    assign port_off = !((state_q == S_RUN) || (state_q == S_DRAIN));

    lenet_bram_port_mux #(
        .N     (NUM_LAYERS),
        .PW    (WADDR_W),
        .SEL_W (LENET_IDX_W)
    ) u_bw_mux (
        .force_off (port_off),
        .sel       (idx_q),
        .ena_in    (bus.eng_bw_ena),
        .pay_in    (bus.eng_bw_addra),
        .ena       (bus.bias_weights_bram_ena),
        .pay       (bus.bias_weights_bram_addra)
    );

    logic [NUM_LAYERS*RS_PW-1:0] rs_pay_in;
    logic [RS_PW-1:0]            rs_pay;

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_rs_pack
        assign rs_pay_in[g*RS_PW +: RS_PW] = {bus.eng_rs_wea[g],
                                              bus.eng_rs_addra[g*RADDR_W +: RADDR_W],
                                              bus.eng_rs_dina[g*DATA_SIZE +: DATA_SIZE]};
    end

    lenet_bram_port_mux #(
        .N     (NUM_LAYERS),
        .PW    (RS_PW),
        .SEL_W (LENET_IDX_W)
    ) u_rs_mux (
        .force_off (port_off),
        .sel       (idx_q),
        .ena_in    (bus.eng_rs_ena),
        .pay_in    (rs_pay_in),
        .ena       (bus.result_bram_ena),
        .pay       (rs_pay)
    );

    assign bus.result_bram_wea   = rs_pay[RS_PW-1];
    assign bus.result_bram_addra = rs_pay[RADDR_W+DATA_SIZE-1 -: RADDR_W];
    assign bus.result_bram_dina  = rs_pay[DATA_SIZE-1:0];

endmodule
